// File: rtl/scan_counter_pkg.sv
// scan_counter_pkg: shared converter state, segment patterns and width helper for the counter display chain
package scan_counter_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;
  localparam logic [7:0] SEG_PAT [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  localparam logic [7:0] SEG_BLANK = 8'h00;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/scan_step_counter_bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle
module bin2bcd_seq
  import scan_counter_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = clog2(CNT_W);
  conv_state_e state_q, state_d;
  logic [CNT_W-1:0] bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] bit_q, bit_d;
  // add 3 to every BCD digit of 5 or more before the next shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) adj[4*i +: 4] = bcd_q[4*i +: 4] > 4'd4 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end
  // FSM: capture on start, shift CNT_W bits, hold one DONE cycle for the result write
  always_comb begin
    state_d = state_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    bit_d = bit_q;
    if (state_q == IDLE && start_i) begin
      state_d = SHIFT;
      bin_d = bin_i;
      bcd_d = '0;
      bit_d = '0;
    end
    if (state_q == SHIFT) begin
      bcd_d = {adj[BW-2:0], bin_q[CNT_W-1]};
      bin_d = bin_q << 1;
      bit_d = bit_q + CW'(1);
      state_d = bit_q == CW'(CNT_W - 1) ? DONE : SHIFT;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  // state registers; reset discards any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      bit_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      bit_q <= bit_d;
    end
  end
  assign busy_o = state_q == SHIFT;
  assign done_o = state_q == DONE;
  assign bcd_o = bcd_q;
endmodule

// File: rtl/scan_step_counter.sv
// scan_step_counter: prescaled up/down step counter feeding a BCD converter and multiplexed 7-segment scanner
module scan_step_counter
  import scan_counter_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int STEP_W   = 4,
  parameter int DIGITS   = 3,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter int BLANK_LZ = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      up_down,
  input  logic [STEP_W-1:0]         step,
  input  logic                      sat_mode,
  input  logic                      load,
  input  logic [CNT_W-1:0]          load_val,
  output logic [CNT_W-1:0]          count,
  output logic                      ovf,
  output logic                      bcd_busy,
  output logic [7:0]                seg,
  output logic [clog2(DIGITS)-1:0]  seg_select
);
  localparam int XW = CNT_W + 1;
  localparam int TW = clog2(TICK_DIV);
  localparam int SW = clog2(SCAN_DIV);
  localparam int LW = clog2(DIGITS);
  localparam int BW = 4 * DIGITS;
  if (64'd10 ** DIGITS <= (64'd1 << CNT_W) - 64'd1) begin : g_digits_check
    $error("DIGITS too small to display the full CNT_W range");
  end
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [CNT_W-1:0] count_q, count_d, last_q, last_d, nxt;
  logic ovf_q, ovf_d, pend_q, pend_d;
  logic [BW-1:0] disp_q, disp_d, bcd;
  logic [LW-1:0] sel_q, sel_d, sel_n;
  logic [7:0] seg_q, seg_d;
  logic [XW-1:0] sum, dif;
  logic [DIGITS:0] lz;
  logic [3:0] dig;
  logic tick, upd, flag, adv, blank, start, conv_busy, conv_done;
  // counter: arithmetic at CNT_W+1 bits exposes carry/borrow; load beats tick
  always_comb begin
    tick = tick_q == TW'(TICK_DIV - 1);
    tick_d = tick ? '0 : tick_q + TW'(1);
    sum = {1'b0, count_q} + XW'(step);
    dif = {1'b0, count_q} - XW'(step);
    flag = up_down ? sum[CNT_W] : dif[CNT_W];
    nxt = (sat_mode && flag) ? {CNT_W{up_down}} : (up_down ? sum[CNT_W-1:0] : dif[CNT_W-1:0]);
    upd = tick && en && !load;
    count_d = load ? load_val : upd ? nxt : count_q;
    ovf_d = upd && flag;
  end
  // converter control: start when the count left the last captured value or a change arrived mid-shift
  always_comb begin
    start = !conv_busy && !conv_done && (count_q != last_q || pend_q);
    last_d = start ? count_q : last_q;
    pend_d = start ? 1'b0 : (conv_busy && count_q != last_q) || pend_q;
    disp_d = conv_done ? bcd : disp_q;
  end
  // scanner: step the digit index and register the pattern of the newly selected digit
  always_comb begin
    adv = scan_q == SW'(SCAN_DIV - 1);
    scan_d = adv ? '0 : scan_q + SW'(1);
    sel_n = sel_q == LW'(DIGITS - 1) ? '0 : sel_q + LW'(1);
    sel_d = adv ? sel_n : sel_q;
    lz = '0;
    lz[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) lz[i] = lz[i+1] && disp_q[4*i +: 4] == 4'd0;
    dig = disp_q[{sel_n, 2'b00} +: 4];
    blank = BLANK_LZ != 0 && sel_n != '0 && lz[sel_n];
    seg_d = adv ? (blank ? SEG_BLANK : SEG_PAT[dig]) : seg_q;
  end
  // state registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tick_q <= '0;
      scan_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      last_q <= '0;
      pend_q <= 1'b0;
      disp_q <= '0;
      sel_q <= '0;
      seg_q <= SEG_PAT[0];
    end else begin
      tick_q <= tick_d;
      scan_q <= scan_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      last_q <= last_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end
  bin2bcd_seq #(.CNT_W(CNT_W), .DIGITS(DIGITS)) u_bcd (
    .clk     (clk),
    .rst     (rst_n),
    .start_i (start),
    .bin_i   (count_q),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );
  assign count = count_q;
  assign ovf = ovf_q;
  assign bcd_busy = conv_busy;
  assign seg = seg_q;
  assign seg_select = sel_q;
endmodule

// File: tb/tb_scan_step_counter.sv
// tb_scan_step_counter: scoreboard bench for counter, converter and scanner
module tb_scan_step_counter;
  typedef struct { logic [7:0] c; logic o; } cnt_exp_t;
  localparam logic [7:0] PAT [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  logic clk, rst_n, en, up_down, sat_mode, load, ovf, bcd_busy;
  logic [3:0] step;
  logic [7:0] load_val, count, seg;
  logic [1:0] seg_select;
  int total, bad, ph, busy_cnt, m_cnt;
  cnt_exp_t cq[$];
  logic [7:0] sq[$];
  logic [1:0] selq[$];

  scan_step_counter #(.CNT_W(8), .STEP_W(4), .DIGITS(3), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .step(step), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .count(count), .ovf(ovf), .bcd_busy(bcd_busy),
    .seg(seg), .seg_select(seg_select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst_n)
    if (rst_n) ph <= 0;
    else ph <= (ph == 3) ? 0 : ph + 1;

  always @(negedge clk)
    if (bcd_busy === 1'b1) busy_cnt <= busy_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cnt_exp_t step_model(input int c, input int ud, input int st, input int sat);
    int n;
    cnt_exp_t r;
    n = ud != 0 ? c + st : c - st;
    r.o = 1'b0;
    if (n > 255) begin r.o = 1'b1; n = sat != 0 ? 255 : n - 256; end
    else if (n < 0) begin r.o = 1'b1; n = sat != 0 ? 0 : n + 256; end
    r.c = n[7:0];
    return r;
  endfunction

  task automatic pop_cnt(input string tag);
    cnt_exp_t e;
    e = cq.pop_front();
    chk({tag, "_count"}, count, e.c);
    chk({tag, "_ovf"}, ovf, e.o);
  endtask

  task automatic wait_tick_cycle();
    int n;
    n = 0;
    while (ph != 3 && n < 8) begin @(negedge clk); n++; end
  endtask

  task automatic tick_step(input string tag);
    cnt_exp_t e;
    wait_tick_cycle();
    if (en) e = step_model(m_cnt, up_down, step, sat_mode);
    else begin e.c = m_cnt[7:0]; e.o = 1'b0; end
    cq.push_back(e);
    m_cnt = e.c;
    @(negedge clk);
    pop_cnt(tag);
    @(negedge clk);
    chk({tag, "_ovf_pulse"}, ovf, 0);
  endtask

  task automatic do_load(input int v, input string tag);
    cnt_exp_t e;
    load = 1'b1;
    load_val = v[7:0];
    e.c = v[7:0];
    e.o = 1'b0;
    cq.push_back(e);
    m_cnt = v;
    @(negedge clk);
    load = 1'b0;
    pop_cnt(tag);
  endtask

  task automatic push_disp(input int v);
    int d0, d1, d2;
    d0 = v % 10;
    d1 = (v / 10) % 10;
    d2 = v / 100;
    sq.push_back(PAT[d0]);
    sq.push_back(d2 == 0 && d1 == 0 ? 8'h00 : PAT[d1]);
    sq.push_back(d2 == 0 ? 8'h00 : PAT[d2]);
  endtask

  task automatic check_display(input string tag);
    int n;
    logic [7:0] e;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (seg_select !== 2'(i) && n < 12) begin @(negedge clk); n++; end
      chk($sformatf("%s_sel%0d", tag, i), seg_select, i);
      e = sq.pop_front();
      chk($sformatf("%s_seg%0d", tag, i), seg, e);
    end
  endtask

  initial begin
    int b0;
    logic [1:0] es;
    cnt_exp_t e;
    rst_n = 1'b0; en = 1'b0; up_down = 1'b1; step = '0; sat_mode = 1'b0; load = 1'b0; load_val = '0;
    m_cnt = 0;
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sel", seg_select, 0);
    chk("rst_seg", seg, 8'h3F);
    chk("rst_busy", bcd_busy, 0);
    for (int k = 1; k <= 8; k++) begin
      es = 2'((k / 2) % 3);
      selq.push_back(es);
      sq.push_back(es == 0 ? 8'h3F : 8'h00);
    end
    rst_n = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("scan_sel_k%0d", k), seg_select, selq.pop_front());
      chk($sformatf("scan_seg_k%0d", k), seg, sq.pop_front());
    end
    do_load(250, "t2_load");
    up_down = 1'b1; step = 4'd9; sat_mode = 1'b0; en = 1'b1;
    tick_step("t2_wrap");
    en = 1'b0;
    push_disp(3);
    check_display("t2_disp");
    do_load(5, "t3_load");
    up_down = 1'b0; step = 4'd15; sat_mode = 1'b1; en = 1'b1;
    tick_step("t3_sat1");
    tick_step("t3_sat2");
    en = 1'b0;
    push_disp(0);
    check_display("t3_disp");
    b0 = busy_cnt;
    up_down = 1'b1; step = 4'd0; sat_mode = 1'b0; en = 1'b1;
    repeat (3) tick_step("t4_step0");
    en = 1'b0; step = 4'd5;
    repeat (2) tick_step("t4_en0");
    chk("t4_busy_cycles", busy_cnt - b0, 0);
    up_down = 1'b1; step = 4'd4; sat_mode = 1'b0; en = 1'b1;
    wait_tick_cycle();
    load = 1'b1; load_val = 8'd123;
    e.c = 8'd123; e.o = 1'b0;
    cq.push_back(e);
    m_cnt = 123;
    @(negedge clk);
    load = 1'b0; en = 1'b0;
    pop_cnt("t5_collide");
    @(negedge clk);
    chk("t5_ovf_after", ovf, 0);
    chk("t5_count_hold", count, 123);
    push_disp(123);
    check_display("t5_disp");
    do_load(200, "t6_load");
    repeat (3) @(negedge clk);
    chk("t6_busy_mid", bcd_busy, 1);
    #2 rst_n = 1'b1;
    #1;
    chk("t6_rst_busy", bcd_busy, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_ovf", ovf, 0);
    chk("t6_rst_seg", seg, 8'h3F);
    chk("t6_rst_sel", seg_select, 0);
    @(negedge clk);
    rst_n = 1'b0;
    m_cnt = 0;
    b0 = busy_cnt;
    push_disp(0);
    check_display("t6_disp");
    chk("t6_no_restart", busy_cnt - b0, 0);
    chk("t6_count_after", count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
